// File: rtl/image_mem_server_if.sv
// Host stream, consumer access bus and result handshake for image_mem_server.
// master = host/consumer side, slave = image_mem_server.
interface image_mem_server_if #(
    parameter int PIX_W = 8
);
    logic             host_valid;
    logic             host_ready;
    logic             host_tem_win;
    logic [PIX_W-1:0] host_data;

    logic             req;
    logic             rd_wr;
    logic             tem_win;
    logic [6:0]       row;
    logic [6:0]       col;
    logic [31:0]      write_data;
    logic [31:0]      read_data;

    logic             ready_2_start;
    logic             set_done;
    logic [63:0]      greatestNCCLog2;
    logic [8:0]       greatestWindowIndex;
    logic [63:0]      res_ncc;
    logic [8:0]       res_index;
    logic             res_valid;
    logic             res_ack;
    logic             err_oob;

    modport master (
        output host_valid, host_tem_win, host_data,
        output req, rd_wr, tem_win, row, col, write_data,
        output set_done, greatestNCCLog2, greatestWindowIndex,
        output res_ack,
        input  host_ready, read_data, ready_2_start,
        input  res_ncc, res_index, res_valid, err_oob
    );

    modport slave (
        input  host_valid, host_tem_win, host_data,
        input  req, rd_wr, tem_win, row, col, write_data,
        input  set_done, greatestNCCLog2, greatestWindowIndex,
        input  res_ack,
        output host_ready, read_data, ready_2_start,
        output res_ncc, res_index, res_valid, err_oob
    );
endinterface

// File: rtl/image_mem_server.sv
// Template/window image buffer: loads both images from a host stream,
// serves consumer row/col accesses, then holds the consumer's result.
// Ports: clk, rst_n (async active-low), bus (image_mem_server_if.slave).
module image_mem_server #(
    parameter int TEM_ROWS = 16,
    parameter int TEM_COLS = 16,
    parameter int WIN_ROWS = 64,
    parameter int WIN_COLS = 64,
    parameter int PIX_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    image_mem_server_if.slave   bus
);
    localparam int TN  = TEM_ROWS * TEM_COLS;
    localparam int WN  = WIN_ROWS * WIN_COLS;
    localparam int TAW = (TN > 1) ? $clog2(TN) : 1;
    localparam int WAW = (WN > 1) ? $clog2(WN) : 1;
    localparam int TCW = $clog2(TN + 1);
    localparam int WCW = $clog2(WN + 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_READY,
        S_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [PIX_W-1:0] tmem [TN];
    logic [PIX_W-1:0] wmem [WN];

    logic [TCW-1:0] tcnt;
    logic [WCW-1:0] wcnt;
    logic           t_full;
    logic           w_full;

    logic           t_oob;
    logic           w_oob;
    logic           acc_oob;
    logic [TAW-1:0] t_acc;
    logic [WAW-1:0] w_acc;

    logic             hrdy;
    logic             h_acc;
    logic             t_we;
    logic             w_we;
    logic [TAW-1:0]   t_waddr;
    logic [WAW-1:0]   w_waddr;
    logic [PIX_W-1:0] wdat;
    logic             rd_en;

    logic [31:0] read_data_q;
    logic        r2s_q;
    logic [63:0] res_ncc_q;
    logic [8:0]  res_index_q;
    logic        res_valid_q;
    logic        err_oob_q;

    assign t_full = (tcnt == TCW'(TN));
    assign w_full = (wcnt == WCW'(WN));

    // 8-bit compares so a 128-row/col buffer never aliases row 127.
    assign t_oob = ({1'b0, bus.row} >= 8'(TEM_ROWS))
                || ({1'b0, bus.col} >= 8'(TEM_COLS));
    assign w_oob = ({1'b0, bus.row} >= 8'(WIN_ROWS))
                || ({1'b0, bus.col} >= 8'(WIN_COLS));
    assign acc_oob = bus.tem_win ? t_oob : w_oob;

    // Only meaningful when in range; then it always fits the address.
    assign t_acc = TAW'(bus.row) * TAW'(TEM_COLS) + TAW'(bus.col);
    assign w_acc = WAW'(bus.row) * WAW'(WIN_COLS) + WAW'(bus.col);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            S_LOAD:  if (t_full && w_full) next_state = S_READY;
            S_READY: if (bus.set_done)     next_state = S_DONE;
            S_DONE:  if (bus.res_ack)      next_state = S_LOAD;
            default: next_state = S_LOAD;
        endcase
    end

    // Output / control decode
    always_comb begin
        hrdy    = 1'b0;
        h_acc   = 1'b0;
        t_we    = 1'b0;
        w_we    = 1'b0;
        t_waddr = t_acc;
        w_waddr = w_acc;
        wdat    = bus.write_data[PIX_W-1:0];
        rd_en   = 1'b0;
        unique case (state)
            S_LOAD: begin
                hrdy  = bus.host_tem_win ? !t_full : !w_full;
                h_acc = bus.host_valid && hrdy;
                wdat  = bus.host_data;
                // Raster order: the fill count is the linear address.
                t_waddr = tcnt[TAW-1:0];
                w_waddr = wcnt[WAW-1:0];
                t_we  = h_acc && bus.host_tem_win;
                w_we  = h_acc && !bus.host_tem_win;
            end
            S_READY: begin
                rd_en = bus.req && bus.rd_wr;
                if (bus.req && !bus.rd_wr && !acc_oob) begin
                    t_we = bus.tem_win;
                    w_we = !bus.tem_win;
                end
            end
            default: ;
        endcase
    end

    assign bus.host_ready = hrdy;

    always_ff @(posedge clk) begin
        if (t_we) tmem[t_waddr] <= wdat;
        if (w_we) wmem[w_waddr] <= wdat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt        <= '0;
            wcnt        <= '0;
            read_data_q <= '0;
            r2s_q       <= 1'b0;
            res_ncc_q   <= '0;
            res_index_q <= '0;
            res_valid_q <= 1'b0;
            err_oob_q   <= 1'b0;
        end else begin
            r2s_q <= (next_state == S_READY);

            if (t_we && state == S_LOAD) tcnt <= tcnt + TCW'(1);
            if (w_we && state == S_LOAD) wcnt <= wcnt + WCW'(1);

            if (rd_en) begin
                if (acc_oob)          read_data_q <= '0;
                else if (bus.tem_win) read_data_q <= 32'(tmem[t_acc]);
                else                  read_data_q <= 32'(wmem[w_acc]);
            end

            if (state == S_READY && bus.req && acc_oob) begin
                err_oob_q <= 1'b1;
            end

            if (state == S_READY && bus.set_done) begin
                res_ncc_q   <= bus.greatestNCCLog2;
                res_index_q <= bus.greatestWindowIndex;
                res_valid_q <= 1'b1;
            end

            // Host took the result: re-arm for a full reload.
            if (state == S_DONE && bus.res_ack) begin
                res_valid_q <= 1'b0;
                tcnt        <= '0;
                wcnt        <= '0;
                read_data_q <= '0;
            end
        end
    end

    assign bus.read_data     = read_data_q;
    assign bus.ready_2_start = r2s_q;
    assign bus.res_ncc       = res_ncc_q;
    assign bus.res_index     = res_index_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.err_oob       = err_oob_q;

endmodule

// File: tb/tb_image_mem_server.sv
// Bench for image_mem_server: read responses are checked by a queued
// scoreboard monitor, control/status outputs by direct expectations.
module tb_image_mem_server;
    localparam int TN = 256;
    localparam int WN = 4096;

    logic clk;
    logic rst_n;

    image_mem_server_if #(.PIX_W(8)) bus ();

    image_mem_server dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    logic chk_rd = 1'b0;

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'((r * c) % 256);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one response per read issued the prior cycle.
    initial begin
        logic f;
        exp_t e;
        forever begin
            @(posedge clk);
            f = chk_rd;
            #1;
            if (f) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: got %0h expected none",
                             bus.read_data);
                end else begin
                    e = exp_q.pop_front();
                    n_chk--;
                    chk(e.name, 64'(bus.read_data), 64'(e.val));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic idle();
        @(negedge clk);
        bus.req  = 1'b0;
        chk_rd   = 1'b0;
    endtask

    task automatic do_read(input string name, input logic tw,
                           input int r, input int c, input logic [31:0] v);
        exp_t e;
        @(negedge clk);
        bus.req     = 1'b1;
        bus.rd_wr   = 1'b1;
        bus.tem_win = tw;
        bus.row     = 7'(r);
        bus.col     = 7'(c);
        chk_rd      = 1'b1;
        e.name      = name;
        e.val       = v;
        exp_q.push_back(e);
    endtask

    task automatic do_write(input logic tw, input int r, input int c,
                            input logic [31:0] d);
        @(negedge clk);
        bus.req        = 1'b1;
        bus.rd_wr      = 1'b0;
        bus.tem_win    = tw;
        bus.row        = 7'(r);
        bus.col        = 7'(c);
        bus.write_data = d;
        chk_rd         = 1'b0;
    endtask

    // Interleave template/window pixels 1:1 until nmax pixels or full.
    task automatic stream(input int nmax);
        int  ti  = 0;
        int  wi  = 0;
        int  n   = 0;
        bit  tog = 1'b1;
        bit  tem;
        while ((ti < TN || wi < WN) && n < nmax) begin
            @(negedge clk);
            tem = (ti < TN) && (tog || wi >= WN);
            bus.host_valid   = 1'b1;
            bus.host_tem_win = tem;
            bus.host_data    = tem ? pix(ti / 16, ti % 16)
                                   : pix(wi / 64, wi % 64);
            #1;
            chk("host_ready_load", 64'(bus.host_ready), 64'(1));
            chk("read_data_load", 64'(bus.read_data), 64'(0));
            chk("r2s_load", 64'(bus.ready_2_start), 64'(0));
            if (tem) ti++;
            else     wi++;
            tog = !tog;
            n++;
        end
        @(negedge clk);
        bus.host_valid = 1'b0;
    endtask

    task automatic check_full_then_ready();
        bus.host_tem_win = 1'b1;
        #1 chk("host_ready_tem_full", 64'(bus.host_ready), 64'(0));
        bus.host_tem_win = 1'b0;
        #1 chk("host_ready_win_full", 64'(bus.host_ready), 64'(0));
        chk("r2s_at_last_accept", 64'(bus.ready_2_start), 64'(0));
        @(negedge clk);
        chk("r2s_one_after", 64'(bus.ready_2_start), 64'(1));
        chk("host_ready_ready", 64'(bus.host_ready), 64'(0));
    endtask

    initial begin
        rst_n                   = 1'b0;
        bus.host_valid          = 1'b0;
        bus.host_tem_win        = 1'b0;
        bus.host_data           = '0;
        bus.req                 = 1'b0;
        bus.rd_wr               = 1'b0;
        bus.tem_win             = 1'b0;
        bus.row                 = '0;
        bus.col                 = '0;
        bus.write_data          = '0;
        bus.set_done            = 1'b0;
        bus.greatestNCCLog2     = '0;
        bus.greatestWindowIndex = '0;
        bus.res_ack             = 1'b0;

        #1;
        chk("rst_read_data", 64'(bus.read_data), 64'(0));
        chk("rst_r2s", 64'(bus.ready_2_start), 64'(0));
        chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
        chk("rst_res_ncc", bus.res_ncc, 64'(0));
        chk("rst_res_index", 64'(bus.res_index), 64'(0));
        chk("rst_err_oob", 64'(bus.err_oob), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.host_tem_win = 1'b1;
        #1 chk("host_ready_after_rst", 64'(bus.host_ready), 64'(1));

        stream(TN + WN);
        check_full_then_ready();

        do_read("rd_w_5_7", 1'b0, 5, 7, 32'd35);
        do_read("rd_w_63_63", 1'b0, 63, 63, 32'(pix(63, 63)));
        do_read("rd_w_2_3", 1'b0, 2, 3, 32'd6);
        do_read("rd_t_15_15", 1'b1, 15, 15, 32'd225);
        do_write(1'b1, 3, 4, 32'hFFFF_FFAB);
        do_read("rd_after_wr", 1'b1, 3, 4, 32'h0000_00AB);
        idle();
        chk("err_oob_clean", 64'(bus.err_oob), 64'(0));

        do_read("rd_oob_row", 1'b1, 20, 0, 32'd0);
        idle();
        chk("err_oob_set", 64'(bus.err_oob), 64'(1));
        do_write(1'b1, 3, 20, 32'h55);
        do_write(1'b0, 64, 0, 32'h77);
        do_read("oob_wr_t_alias", 1'b1, 4, 4, 32'd16);
        do_read("oob_wr_w_alias", 1'b0, 0, 0, 32'd0);
        do_read("rd_oob_col", 1'b0, 1, 64, 32'd0);
        do_read("rd_w_9_9", 1'b0, 9, 9, 32'd81);
        idle();
        chk("err_oob_sticky", 64'(bus.err_oob), 64'(1));

        do_read("rd_with_done", 1'b0, 10, 10, 32'd100);
        bus.set_done            = 1'b1;
        bus.greatestNCCLog2     = 64'h0123_4567_89AB_CDEF;
        bus.greatestWindowIndex = 9'd300;
        @(negedge clk);
        bus.set_done = 1'b0;
        bus.req      = 1'b0;
        chk_rd       = 1'b0;
        bus.greatestNCCLog2     = '0;
        bus.greatestWindowIndex = '0;
        #1;
        chk("res_valid_set", 64'(bus.res_valid), 64'(1));
        chk("res_ncc", bus.res_ncc, 64'h0123_4567_89AB_CDEF);
        chk("res_index", 64'(bus.res_index), 64'(300));
        chk("r2s_cleared", 64'(bus.ready_2_start), 64'(0));

        @(negedge clk);
        bus.req     = 1'b1;
        bus.rd_wr   = 1'b1;
        bus.tem_win = 1'b0;
        bus.row     = 7'd2;
        bus.col     = 7'd3;
        bus.set_done = 1'b1;
        @(negedge clk);
        bus.req      = 1'b0;
        bus.set_done = 1'b0;
        #1;
        chk("done_read_held", 64'(bus.read_data), 64'(100));
        chk("done_res_valid", 64'(bus.res_valid), 64'(1));
        chk("done_res_ncc", bus.res_ncc, 64'h0123_4567_89AB_CDEF);
        bus.res_ack = 1'b1;
        bus.host_tem_win = 1'b1;
        #1 chk("done_host_ready", 64'(bus.host_ready), 64'(0));
        @(negedge clk);
        bus.res_ack = 1'b0;
        #1;
        chk("ack_res_valid", 64'(bus.res_valid), 64'(0));
        chk("ack_host_ready", 64'(bus.host_ready), 64'(1));
        chk("ack_read_data", 64'(bus.read_data), 64'(0));
        chk("ack_err_oob", 64'(bus.err_oob), 64'(1));

        stream(100);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_read_data", 64'(bus.read_data), 64'(0));
        chk("mid_rst_r2s", 64'(bus.ready_2_start), 64'(0));
        chk("mid_rst_res_valid", 64'(bus.res_valid), 64'(0));
        chk("mid_rst_res_ncc", bus.res_ncc, 64'(0));
        chk("mid_rst_res_index", 64'(bus.res_index), 64'(0));
        chk("mid_rst_err_oob", 64'(bus.err_oob), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        bus.host_tem_win = 1'b0;
        #1 chk("host_ready_rerst", 64'(bus.host_ready), 64'(1));

        stream(TN + WN);
        check_full_then_ready();
        do_read("reload_t_3_4", 1'b1, 3, 4, 32'd12);
        do_read("reload_w_63_63", 1'b0, 63, 63, 32'(pix(63, 63)));
        idle();
        idle();
        chk("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
